// File: rtl/mem_align_if.sv
// Bus bundle between the MEM-stage control/datapath and the load/store
// alignment unit. The unit sits on the slave side.
interface mem_align_if #(
    parameter int ERR_W = 8
);
    // Pipeline control
    logic             stall;
    logic             flush;
    logic             valid_in;

    // Access description
    logic [2:0]       mem_op;
    logic [31:0]      addr;
    logic [31:0]      store_data;
    logic [31:0]      mem_rdata;

    // Data-memory write port
    logic [3:0]       dmem_we;
    logic [31:0]      dmem_wdata;

    // MEM/WB boundary
    logic [31:0]      load_data_q;
    logic             load_valid_q;
    logic             misalign_q;
    logic [ERR_W-1:0] err_count_q;

    // Pipeline/control side: drives the access, observes results
    modport master (
        output stall, flush, valid_in, mem_op, addr, store_data, mem_rdata,
        input  dmem_we, dmem_wdata, load_data_q, load_valid_q, misalign_q, err_count_q
    );

    // Alignment unit side
    modport slave (
        input  stall, flush, valid_in, mem_op, addr, store_data, mem_rdata,
        output dmem_we, dmem_wdata, load_data_q, load_valid_q, misalign_q, err_count_q
    );
endinterface

// File: rtl/mem_align_unit.sv
// MEM-stage load/store alignment unit for the pipelined MIPS core.
// Stores: lane replication and byte enables, purely combinational.
// Loads: byte/halfword extraction with sign/zero extension, registered
// into the MEM/WB boundary. Misaligned accesses are flagged and counted.
module mem_align_unit #(
    parameter int ERR_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    mem_align_if.slave bus
);

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LH  = 3'b001,
        OP_LHU = 3'b010,
        OP_LB  = 3'b011,
        OP_LBU = 3'b100,
        OP_SW  = 3'b101,
        OP_SH  = 3'b110,
        OP_SB  = 3'b111
    } mem_op_e;

    mem_op_e    op;
    logic [1:0] lane;

    assign op   = mem_op_e'(bus.mem_op);
    assign lane = bus.addr[1:0];

    // Only the word offset matters here; the upper address goes straight to memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr[31:2];

    // ------------------------------------------------------------------
    // Operation decode
    // ------------------------------------------------------------------
    logic is_load;
    logic st_word;
    logic st_half;
    logic st_byte;
    logic misaligned;

    // Classify the access and check its natural alignment
    always_comb begin
        is_load    = 1'b0;
        st_word    = 1'b0;
        st_half    = 1'b0;
        st_byte    = 1'b0;
        misaligned = 1'b0;
        case (op)
            OP_LW: begin
                is_load    = 1'b1;
                misaligned = (lane != 2'b00);
            end
            OP_LH, OP_LHU: begin
                is_load    = 1'b1;
                misaligned = lane[0];
            end
            OP_LB, OP_LBU: begin
                is_load    = 1'b1;
            end
            OP_SW: begin
                st_word    = 1'b1;
                misaligned = (lane != 2'b00);
            end
            OP_SH: begin
                st_half    = 1'b1;
                misaligned = lane[0];
            end
            OP_SB: begin
                st_byte    = 1'b1;
            end
            default: begin
                is_load    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Store path: replicate the narrow value into every lane it could land
    // in, then let the byte enables pick the lane(s) actually written.
    // ------------------------------------------------------------------
    logic [3:0]  we_lane;
    logic [31:0] wdata_lane;
    logic        write_ok;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_store_lane
            assign wdata_lane[8*gi +: 8] =
                st_byte ? bus.store_data[7:0] :
                st_half ? bus.store_data[8*(gi%2) +: 8] :
                          bus.store_data[8*gi +: 8];

            assign we_lane[gi] =
                st_word |
                (st_half & (lane[1] == 1'(gi/2))) |
                (st_byte & (lane == 2'(gi)));
        end
    endgenerate

    // Memory is written at this same edge, so anything that cancels the
    // instruction must also cancel its byte enables.
    assign write_ok       = bus.valid_in & ~bus.stall & ~bus.flush & ~reset & ~misaligned;
    assign bus.dmem_we    = write_ok ? we_lane : 4'b0000;
    assign bus.dmem_wdata = wdata_lane;

    // ------------------------------------------------------------------
    // Load path: split the read word into lanes, select, extend.
    // ------------------------------------------------------------------
    logic [7:0]  rd_byte [4];
    logic [15:0] rd_half [2];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_rd_byte
            assign rd_byte[gi] = bus.mem_rdata[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_rd_half
            assign rd_half[gi] = bus.mem_rdata[16*gi +: 16];
        end
    endgenerate

    assign sel_byte = rd_byte[lane];
    assign sel_half = rd_half[lane[1]];

    // Sign- or zero-extend the selected lane according to the load type
    always_comb begin
        load_ext = 32'h0000_0000;
        case (op)
            OP_LW:   load_ext = bus.mem_rdata;
            OP_LH:   load_ext = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  load_ext = {16'h0000, sel_half};
            OP_LB:   load_ext = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_ext = {24'h000000, sel_byte};
            default: load_ext = 32'h0000_0000;
        endcase
    end

    // ------------------------------------------------------------------
    // MEM/WB boundary registers
    // ------------------------------------------------------------------
    logic [31:0]      load_data_reg,  load_data_next;
    logic             load_valid_reg, load_valid_next;
    logic             misalign_reg,   misalign_next;
    logic [ERR_W-1:0] err_count_reg,  err_count_next;
    logic             good_load;
    logic             bad_access;

    assign good_load  = bus.valid_in & is_load & ~misaligned;
    assign bad_access = bus.valid_in & misaligned;

    // Next-state: flush clears the slot, stall holds everything, else capture
    always_comb begin
        load_data_next  = load_data_reg;
        load_valid_next = load_valid_reg;
        misalign_next   = misalign_reg;
        err_count_next  = err_count_reg;
        if (bus.flush) begin
            load_data_next  = 32'h0000_0000;
            load_valid_next = 1'b0;
            misalign_next   = 1'b0;
        end else if (!bus.stall) begin
            load_data_next  = good_load ? load_ext : 32'h0000_0000;
            load_valid_next = good_load;
            misalign_next   = bad_access;
            // Saturate rather than wrap so a long fault storm stays visible
            if (bad_access && !(&err_count_reg)) begin
                err_count_next = err_count_reg + {{(ERR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // State registers with synchronous reset taking priority over flush/stall
    always_ff @(posedge clk) begin
        if (reset) begin
            load_data_reg  <= 32'h0000_0000;
            load_valid_reg <= 1'b0;
            misalign_reg   <= 1'b0;
            err_count_reg  <= '0;
        end else begin
            load_data_reg  <= load_data_next;
            load_valid_reg <= load_valid_next;
            misalign_reg   <= misalign_next;
            err_count_reg  <= err_count_next;
        end
    end

    assign bus.load_data_q  = load_data_reg;
    assign bus.load_valid_q = load_valid_reg;
    assign bus.misalign_q   = misalign_reg;
    assign bus.err_count_q  = err_count_reg;

endmodule

// File: tb/tb_mem_align_unit.sv
// Self-checking bench for mem_align_unit: store outputs are checked in the
// same cycle, register outputs through a scoreboard queue one edge later.
module tb_mem_align_unit;

    localparam int ERR_W = 8;

    localparam logic [2:0] LW  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LHU = 3'd2;
    localparam logic [2:0] LB  = 3'd3;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] SW  = 3'd5;
    localparam logic [2:0] SH  = 3'd6;
    localparam logic [2:0] SB  = 3'd7;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_align_if #(.ERR_W(ERR_W)) bus ();

    mem_align_unit #(.ERR_W(ERR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0]      data;
        logic             valid;
        logic             mis;
        logic [ERR_W-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t model;
    int   total = 0;
    int   bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, want);
        end
    endtask

    function automatic logic is_mis(input logic [2:0] op, input logic [31:0] a);
        if (op == LW || op == SW) return a[1:0] != 2'b00;
        if (op == LH || op == LHU || op == SH) return a[0];
        return 1'b0;
    endfunction

    function automatic logic [31:0] ext_load(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [15:0] h;
        logic [7:0]  b;
        h = a[1] ? rd[31:16] : rd[15:0];
        case (a[1:0])
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        case (op)
            LW:      return rd;
            LH:      return {{16{h[15]}}, h};
            LHU:     return {16'h0, h};
            LB:      return {{24{b[7]}}, b};
            LBU:     return {24'h0, b};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] exp_we(input logic [2:0] op, input logic [31:0] a,
                                          input logic v, input logic st, input logic fl,
                                          input logic rs);
        if (!v || st || fl || rs || is_mis(op, a)) return 4'b0000;
        case (op)
            SW:      return 4'b1111;
            SH:      return a[1] ? 4'b1100 : 4'b0011;
            SB:      return 4'b0001 << a[1:0];
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] op, input logic [31:0] sd);
        if (op == SH) return {2{sd[15:0]}};
        if (op == SB) return {4{sd[7:0]}};
        return sd;
    endfunction

    // One transaction: drive, check store outputs, predict, clock, check registers
    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd,
                        input logic st, input logic fl, input logic rs);
        exp_t nxt;
        exp_t got;
        logic m;
        logic ld;
        bus.valid_in   = v;
        bus.mem_op     = op;
        bus.addr       = a;
        bus.store_data = sd;
        bus.mem_rdata  = rd;
        bus.stall      = st;
        bus.flush      = fl;
        reset          = rs;
        #1;
        check_val("dmem_we", 32'(bus.dmem_we), 32'(exp_we(op, a, v, st, fl, rs)));
        check_val("dmem_wdata", bus.dmem_wdata, exp_wdata(op, sd));

        nxt = model;
        m   = is_mis(op, a);
        ld  = (op <= LBU);
        if (rs) begin
            nxt = '0;
        end else if (fl) begin
            nxt.data  = 32'h0;
            nxt.valid = 1'b0;
            nxt.mis   = 1'b0;
        end else if (!st) begin
            nxt.valid = v & ld & ~m;
            nxt.data  = nxt.valid ? ext_load(op, a, rd) : 32'h0;
            nxt.mis   = v & m;
            if (v && m && nxt.cnt != {ERR_W{1'b1}}) nxt.cnt = nxt.cnt + 1'b1;
        end
        model = nxt;
        sb_q.push_back(nxt);

        @(posedge clk);
        #1;
        check_val("sb_depth", sb_q.size(), 1);
        if (sb_q.size() != 0) begin
            got = sb_q.pop_front();
            check_val("load_data_q", bus.load_data_q, got.data);
            check_val("load_valid_q", 32'(bus.load_valid_q), 32'(got.valid));
            check_val("misalign_q", 32'(bus.misalign_q), 32'(got.mis));
            check_val("err_count_q", 32'(bus.err_count_q), 32'(got.cnt));
        end
        $display("txn op=%0d addr=%h v=%b st=%b fl=%b rs=%b we=%b wd=%h -> ld=%h lv=%b mis=%b cnt=%0d",
                 op, a, v, st, fl, rs, bus.dmem_we, bus.dmem_wdata,
                 bus.load_data_q, bus.load_valid_q, bus.misalign_q, bus.err_count_q);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model = '0;
        // Reset
        step(1, LW, 32'h0, 32'h0, 32'h0, 0, 0, 1);
        step(0, LW, 32'h0, 32'h0, 32'h0, 0, 0, 1);

        // Load extraction
        step(1, LB,  32'h13, 32'h0, 32'h80123456, 0, 0, 0);
        step(1, LBU, 32'h13, 32'h0, 32'h80123456, 0, 0, 0);
        step(1, LH,  32'h02, 32'h0, 32'h80017FFF, 0, 0, 0);
        step(1, LHU, 32'h02, 32'h0, 32'h80017FFF, 0, 0, 0);
        step(1, LH,  32'h00, 32'h0, 32'h80017FFF, 0, 0, 0);
        step(1, LW,  32'h08, 32'h0, 32'hDEADBEEF, 0, 0, 0);
        step(1, LB,  32'h21, 32'h0, 32'h00007F00, 0, 0, 0);

        // Store placement
        step(1, SH, 32'h06, 32'h1234ABCD, 32'h0, 0, 0, 0);
        step(1, SH, 32'h04, 32'h1234ABCD, 32'h0, 0, 0, 0);
        step(1, SB, 32'h01, 32'h000000EE, 32'h0, 0, 0, 0);
        step(1, SB, 32'h03, 32'h000000A5, 32'h0, 0, 0, 0);
        step(1, SW, 32'h00, 32'hCAFEF00D, 32'h0, 0, 0, 0);

        // Misalignment
        step(1, SW, 32'h01, 32'h11223344, 32'h0, 0, 0, 0);
        step(1, LW, 32'h02, 32'h0, 32'h55667788, 0, 0, 0);
        step(1, SH, 32'h03, 32'h0, 32'h0, 0, 0, 0);
        step(0, SW, 32'h02, 32'h0, 32'h0, 0, 0, 0);

        // Stall holds, flush clears with priority over stall
        step(1, LBU, 32'h13, 32'h0, 32'h80123456, 0, 0, 0);
        step(1, LW,  32'h00, 32'h0, 32'h11111111, 1, 0, 0);
        step(1, SW,  32'h00, 32'h12345678, 32'h0, 1, 0, 0);
        step(1, SW,  32'h01, 32'h0, 32'h0, 1, 0, 0);
        step(1, LW,  32'h00, 32'h0, 32'h22222222, 1, 1, 0);
        step(1, SW,  32'h02, 32'h0, 32'h0, 0, 1, 0);

        // Mixed random traffic
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom,
                 $urandom, $urandom, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0, 0);
        end

        // Saturation of the error counter
        for (int i = 0; i < 300; i++) begin
            step(1, SW, 32'h03, 32'h0, 32'h0, 0, 0, 0);
        end

        // Reset clears everything, including during stall/flush
        step(1, LW, 32'h00, 32'h0, 32'h0, 0, 0, 1);
        step(1, LB, 32'h03, 32'h0, 32'hFF000000, 0, 0, 0);
        step(1, SW, 32'h01, 32'h0, 32'h0, 0, 0, 0);
        step(1, LW, 32'h00, 32'h0, 32'h0, 1, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
